pwm_duty_meter: RTL and testbench
=================================

// Module: pwm_duty_meter
// PURPOSE
//   Multi-channel successor to the single-channel comparator on-time counter.
//   Each channel measures the high time of its comparator output (joystick PWM) over a fixed window.
//   It scales that count to WIDTH bits and optionally smooths it with an exponential moving average.
//   Flags channels whose comparator is stuck. Output feeds the seven-segment display path.
// PARAMETERS
//   CHANNELS      2    number of comparator inputs measured in parallel
//   WIDTH         7    bits per duty result (full scale 2^WIDTH-1)
//   PER_LOG2      10   window length = 2^PER_LOG2 clk cycles; PER_LOG2 >= WIDTH
//   AVG_SHIFT     0    EMA weight 1/2^AVG_SHIFT; 0 = raw result, no smoothing
//   STUCK_WINDOWS 4    consecutive all-high/all-low windows before stuck flag sets (>=1)
// PORTS
//   clk    in   1                system clock, all logic on rising edge
//   rst    in   1                synchronous, active-high reset
//   en     in   1                measurement enable
//   comp   in   CHANNELS         asynchronous comparator outputs, bit i = channel i
//   duty   out  CHANNELS*WIDTH   duty results, channel i at [i*WIDTH +: WIDTH]
//   valid  out  1                one-cycle strobe: duty/stuck just updated
//   stuck  out  CHANNELS         channel comparator constant for STUCK_WINDOWS windows
// BEHAVIOUR
//   Reset: duty=0, valid=0, stuck=0, window/high counters=0, EMA acc=0, primed=0, sync flops=0.
//   Input sync: comp passes 2 flops -> s[i]; 2-cycle latency; sync flops run regardless of en.
//   Window counter win (PER_LOG2 bits) advances only when en=1; high_cnt[i] (PER_LOG2+1 bits) += s[i] per en cycle.
//   End of window = en=1 and win==2^PER_LOG2-1. In that cycle, total[i] = high_cnt[i] + s[i].
//   raw[i] = (total==2^PER_LOG2) ? 2^WIDTH-1 : total >> (PER_LOG2-WIDTH)  (saturate, never wrap).
//   On the edge closing the window: win<=0, high_cnt<=0, duty/stuck updated, valid<=1 for exactly 1 cycle.
//   So valid rises on the edge after the 2^PER_LOG2-th enabled cycle; period = 2^PER_LOG2 en cycles.
//   EMA: acc[i] width WIDTH+AVG_SHIFT, unsigned.
//     If primed=0: acc <= raw<<AVG_SHIFT (seed); primed<=1.
//     Else: acc <= acc + raw - (acc>>AVG_SHIFT).
//     duty = acc >> AVG_SHIFT, taken from the updated acc. No overflow is possible by construction.
//   Stuck: per-channel counter saturates at STUCK_WINDOWS.
//     Increments on each window with total==0 or total==2^PER_LOG2; clears to 0 on any other window.
//     stuck[i] = (counter==STUCK_WINDOWS). Updated in the same cycle as duty.
//   en=0: win and high_cnt are cleared to 0; the partial window is discarded.
//     duty, acc, stuck and primed hold; valid=0. Measurement restarts from win=0 on re-enable.
//   rst mid-window: all state returns to reset values next edge; the partial window is discarded.
//   Simultaneous rst and window end: rst wins, so no valid is produced.
//   Channels are fully independent; all share win and the single valid strobe.
// TESTING (CHANNELS=2, WIDTH=7, PER_LOG2=10, STUCK_WINDOWS=4 unless noted)
//   Raw scaling: ch0 high 256 of 1024 cycles, ch1 high 512
//     -> duty0=32, duty1=64; valid high 1 cycle every 1024 clks.
//   Saturation/stuck: ch0 held high
//     -> duty0=127; stuck0=0 after windows 1-3, stuck0=1 at the 4th valid.
//     Then 50% input -> stuck0=0, duty0=64 at the next valid.
//   Held low: ch1=0 -> duty1=0; stuck1=1 from the 4th valid.
//   EMA (AVG_SHIFT=2): window 1 at 0% seeds acc=0 (duty=0); then 100% input
//     -> duty = 31, 55, 73 at the next 3 valids.
//   Reset/enable: rst pulsed at cycle 500 of a window -> duty=0, valid=0, stuck=0;
//     first valid is 1024 en cycles after release.
//     en dropped mid-window -> duty holds, no valid; next valid 1024 en cycles after re-enable.
//   Sync latency: a comp edge lands exactly on window end -> it counts 2 cycles later, not in that window.

Source files
------------

// File: rtl/pwm_duty_meter.sv
// pwm_duty_meter
//   Measures the high time of each comparator output (joystick PWM) over a
//   fixed window of 2^PER_LOG2 enabled clock cycles. Each window's count is
//   scaled to WIDTH bits, with a full-high window saturating to full scale.
//   The result can optionally be smoothed by an exponential moving average.
//   A channel is flagged stuck once its comparator has been constant for
//   STUCK_WINDOWS consecutive windows.
//
// Ports
//   clk    system clock, rising edge
//   rst    synchronous active-high reset
//   en     measurement enable; low discards the partial window
//   comp   asynchronous comparator outputs, bit i = channel i
//   duty   duty results, channel i at [i*WIDTH +: WIDTH]
//   valid  one-cycle strobe, duty/stuck updated on this cycle
//   stuck  per-channel stuck flag
module pwm_duty_meter #(
    parameter int CHANNELS      = 2,
    parameter int WIDTH         = 7,
    parameter int PER_LOG2      = 10,
    parameter int AVG_SHIFT     = 0,
    parameter int STUCK_WINDOWS = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      en,
    input  logic [CHANNELS-1:0]       comp,
    output logic [CHANNELS*WIDTH-1:0] duty,
    output logic                      valid,
    output logic [CHANNELS-1:0]       stuck
);

    localparam int AW   = WIDTH + AVG_SHIFT;
    localparam int SW   = $clog2(STUCK_WINDOWS + 1);
    localparam int DROP = PER_LOG2 - WIDTH;

    localparam logic [PER_LOG2:0] FULL      = (PER_LOG2+1)'(1) << PER_LOG2;
    localparam logic [WIDTH-1:0]  RAW_MAX   = '1;
    localparam logic [SW-1:0]     STUCK_MAX = SW'(STUCK_WINDOWS);

    logic [CHANNELS-1:0] comp_meta;
    logic [CHANNELS-1:0] comp_sync;
    logic [PER_LOG2-1:0] win;
    logic [PER_LOG2:0]   high_cnt  [CHANNELS];
    logic [AW-1:0]       acc       [CHANNELS];
    logic [SW-1:0]       stuck_cnt [CHANNELS];
    logic                primed;

    logic                      win_end;
    logic [PER_LOG2:0]         total      [CHANNELS];
    logic [WIDTH-1:0]          raw        [CHANNELS];
    logic [AW-1:0]             acc_next   [CHANNELS];
    logic [SW-1:0]             stuck_next [CHANNELS];
    logic [CHANNELS*WIDTH-1:0] duty_next;

    assign win_end = en && (win == '1);

    always_comb begin
        duty_next = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            // The sample arriving on the closing cycle still belongs to this window.
            total[i] = high_cnt[i] + (PER_LOG2+1)'(comp_sync[i]);

            // A fully-high window would shift to 2^WIDTH and wrap to zero; clamp it.
            raw[i] = (total[i] == FULL) ? RAW_MAX : WIDTH'(total[i] >> DROP);

            // First window after reset seeds the average so it does not ramp up from zero.
            if (!primed) begin
                acc_next[i] = AW'(raw[i]) << AVG_SHIFT;
            end else begin
                acc_next[i] = AW'({1'b0, acc[i]} + (AW+1)'(raw[i])
                                  - (AW+1)'(acc[i] >> AVG_SHIFT));
            end
            duty_next[i*WIDTH +: WIDTH] = WIDTH'(acc_next[i] >> AVG_SHIFT);

            if ((total[i] == '0) || (total[i] == FULL)) begin
                stuck_next[i] = (stuck_cnt[i] == STUCK_MAX) ? STUCK_MAX
                                                            : stuck_cnt[i] + SW'(1);
            end else begin
                stuck_next[i] = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            comp_meta <= '0;
            comp_sync <= '0;
            win       <= '0;
            valid     <= 1'b0;
            primed    <= 1'b0;
            duty      <= '0;
            stuck     <= '0;
            for (int i = 0; i < CHANNELS; i++) begin
                high_cnt[i]  <= '0;
                acc[i]       <= '0;
                stuck_cnt[i] <= '0;
            end
        end else begin
            comp_meta <= comp;
            comp_sync <= comp_meta;
            valid     <= win_end;
            if (!en) begin
                win <= '0;
                for (int i = 0; i < CHANNELS; i++) begin
                    high_cnt[i] <= '0;
                end
            end else if (win_end) begin
                win    <= '0;
                primed <= 1'b1;
                duty   <= duty_next;
                for (int i = 0; i < CHANNELS; i++) begin
                    high_cnt[i]  <= '0;
                    acc[i]       <= acc_next[i];
                    stuck_cnt[i] <= stuck_next[i];
                    stuck[i]     <= (stuck_next[i] == STUCK_MAX);
                end
            end else begin
                win <= win + PER_LOG2'(1);
                for (int i = 0; i < CHANNELS; i++) begin
                    high_cnt[i] <= total[i];
                end
            end
        end
    end

endmodule

// File: tb/tb_pwm_duty_meter.sv
// Bench for pwm_duty_meter: one raw instance (no smoothing) and one with
// AVG_SHIFT=2 share clk/rst/en; each has its own comparator inputs.
module tb_pwm_duty_meter;

    localparam int PERIOD = 1024;
    localparam int RAWMAX = 127;
    localparam int NSTUCK = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en  = 1'b1;
    logic [1:0]  comp_a = '0;
    logic [1:0]  comp_b = '0;
    logic [13:0] duty_a, duty_b;
    logic        valid_a, valid_b;
    logic [1:0]  stuck_a, stuck_b;

    always #5 clk = ~clk;

    pwm_duty_meter #(.CHANNELS(2), .WIDTH(7), .PER_LOG2(10), .AVG_SHIFT(0), .STUCK_WINDOWS(4)) dut_a (
        .clk(clk), .rst(rst), .en(en), .comp(comp_a),
        .duty(duty_a), .valid(valid_a), .stuck(stuck_a)
    );

    pwm_duty_meter #(.CHANNELS(2), .WIDTH(7), .PER_LOG2(10), .AVG_SHIFT(2), .STUCK_WINDOWS(4)) dut_b (
        .clk(clk), .rst(rst), .en(en), .comp(comp_b),
        .duty(duty_b), .valid(valid_b), .stuck(stuck_b)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Per window: count how many enabled cycles saw the comparator high
    // (comparator seen two clocks late), then apply scaling, EMA and stuck rules.
    logic [1:0] m_comp [2];
    int  m_h1 [2][2], m_h2 [2][2], m_high [2][2], m_acc [2][2], m_stk [2][2];
    int  e_duty [2][2];
    bit  e_stuck [2][2];
    bit  m_primed [2];
    bit  e_valid = 1'b0;
    bit  m_live = 1'b0;
    bit  m_wend;
    int  m_cnt, m_s, m_total, m_raw, m_sh;

    always @(posedge clk) begin
        m_comp[0] = comp_a;
        m_comp[1] = comp_b;
        if (rst) begin
            m_live  = 1'b1;
            m_cnt   = 0;
            e_valid = 1'b0;
            for (int d = 0; d < 2; d++) begin
                m_primed[d] = 1'b0;
                for (int i = 0; i < 2; i++) begin
                    m_h1[d][i] = 0; m_h2[d][i] = 0; m_high[d][i] = 0;
                    m_acc[d][i] = 0; m_stk[d][i] = 0;
                    e_duty[d][i] = 0; e_stuck[d][i] = 1'b0;
                end
            end
        end else begin
            m_wend = en && (m_cnt == PERIOD - 1);
            for (int d = 0; d < 2; d++) begin
                m_sh = (d == 0) ? 0 : 2;
                for (int i = 0; i < 2; i++) begin
                    m_s        = m_h2[d][i];
                    m_h2[d][i] = m_h1[d][i];
                    m_h1[d][i] = int'(m_comp[d][i]);
                    if (!en) begin
                        m_high[d][i] = 0;
                    end else begin
                        m_high[d][i] += m_s;
                        if (m_wend) begin
                            m_total = m_high[d][i];
                            m_raw   = (m_total == PERIOD) ? RAWMAX : m_total / 8;
                            if (!m_primed[d]) m_acc[d][i] = m_raw << m_sh;
                            else m_acc[d][i] = m_acc[d][i] + m_raw - (m_acc[d][i] >> m_sh);
                            e_duty[d][i] = m_acc[d][i] >> m_sh;
                            if (m_total == 0 || m_total == PERIOD)
                                m_stk[d][i] = (m_stk[d][i] < NSTUCK) ? m_stk[d][i] + 1 : NSTUCK;
                            else
                                m_stk[d][i] = 0;
                            e_stuck[d][i] = (m_stk[d][i] == NSTUCK);
                            m_high[d][i] = 0;
                        end
                    end
                end
            end
            if (m_wend) begin
                m_primed[0] = 1'b1;
                m_primed[1] = 1'b1;
            end
            m_cnt   = (!en || m_wend) ? 0 : m_cnt + 1;
            e_valid = m_wend;
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (m_live) begin
            chk("valid_a", int'(valid_a), int'(e_valid));
            chk("valid_b", int'(valid_b), int'(e_valid));
            for (int i = 0; i < 2; i++) begin
                chk($sformatf("duty_a ch%0d", i), int'(duty_a[i*7 +: 7]), e_duty[0][i]);
                chk($sformatf("duty_b ch%0d", i), int'(duty_b[i*7 +: 7]), e_duty[1][i]);
                chk($sformatf("stuck_a ch%0d", i), int'(stuck_a[i]), int'(e_stuck[0][i]));
                chk($sformatf("stuck_b ch%0d", i), int'(stuck_b[i]), int'(e_stuck[1][i]));
            end
        end
    end

    // ---------------- stimulus ----------------
    // Pattern position j within a 1024-cycle period; channel high while j < hi.
    task automatic drive(input int start, input int n,
                         input int ha0, input int ha1, input int hb0, input int hb1);
        for (int j = start; j < start + n; j++) begin
            comp_a[0] = (j < ha0);
            comp_a[1] = (j < ha1);
            comp_b[0] = (j < hb0);
            comp_b[1] = (j < hb1);
            @(negedge clk);
        end
    endtask

    task automatic run_window(input int ha0, input int ha1, input int hb0, input int hb1);
        drive(0, PERIOD, ha0, ha1, hb0, hb1);
        chk("valid at window end", int'(valid_a), 1);
    endtask

    int ema_lit [3] = '{31, 55, 73};

    initial begin
        rst = 1'b1;
        en  = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset duty_a", int'(duty_a), 0);
        chk("reset duty_b", int'(duty_b), 0);
        chk("reset valid", int'(valid_a), 0);
        chk("reset stuck", int'(stuck_a), 0);
        rst = 1'b0;

        // Raw scaling on A; EMA seed then 100% on B ch0; B ch1 held low.
        run_window(256, 512, 0, 0);
        chk("scale a0 25%", int'(duty_a[6:0]), 32);
        chk("scale a1 50%", int'(duty_a[13:7]), 64);
        chk("ema seed b0", int'(duty_b[6:0]), 0);
        chk("model ema seed", e_duty[1][0], 0);
        chk("held low stuck b1 w1", int'(stuck_b[1]), 0);
        for (int w = 2; w <= 4; w++) begin
            run_window(256, 512, 1024, 0);
            chk("scale a0 25%", int'(duty_a[6:0]), 32);
            chk("scale a1 50%", int'(duty_a[13:7]), 64);
            chk($sformatf("ema b0 w%0d", w), int'(duty_b[6:0]), ema_lit[w-2]);
            chk($sformatf("model ema w%0d", w), e_duty[1][0], ema_lit[w-2]);
            chk("held low duty b1", int'(duty_b[13:7]), 0);
            chk($sformatf("held low stuck b1 w%0d", w), int'(stuck_b[1]), (w == 4) ? 1 : 0);
        end

        // A ch0 held high: saturation, stuck after 4 fully-high windows.
        for (int w = 1; w <= 6; w++) begin
            run_window(1024, 512, 1024, 0);
            chk("saturate a0", int'(duty_a[6:0]), RAWMAX);
            chk($sformatf("stuck a0 w%0d", w), int'(stuck_a[0]), (w >= 5) ? 1 : 0);
            chk($sformatf("model stuck a0 w%0d", w), int'(e_stuck[0][0]), (w >= 5) ? 1 : 0);
        end
        run_window(512, 512, 1024, 0);
        chk("unstuck duty a0", int'(duty_a[6:0]), 64);
        chk("unstuck stuck a0", int'(stuck_a[0]), 0);
        run_window(256, 512, 512, 0);

        // Reset mid-window.
        drive(0, 500, 256, 512, 512, 0);
        rst = 1'b1;
        @(negedge clk);
        chk("mid rst duty_a", int'(duty_a), 0);
        chk("mid rst duty_b", int'(duty_b), 0);
        chk("mid rst valid", int'(valid_a), 0);
        chk("mid rst stuck_b", int'(stuck_b), 0);
        rst = 1'b0;
        drive(0, PERIOD - 1, 256, 512, 0, 0);
        chk("no early valid after rst", int'(valid_a), 0);
        drive(PERIOD - 1, 1, 256, 512, 0, 0);
        chk("first valid 1024 after rst", int'(valid_a), 1);
        chk("duty after rst", int'(duty_a[6:0]), 32);

        // Reset on the window-closing cycle: no valid.
        drive(0, PERIOD - 1, 256, 512, 0, 0);
        rst = 1'b1;
        @(negedge clk);
        chk("rst wins over window end", int'(valid_a), 0);
        chk("rst wins duty", int'(duty_a), 0);
        rst = 1'b0;
        run_window(256, 512, 0, 0);
        chk("duty after rst at end", int'(duty_a[6:0]), 32);

        // Enable dropped mid-window.
        drive(0, 300, 1024, 1024, 1024, 1024);
        en = 1'b0;
        comp_a = '0;
        comp_b = '0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            chk("en low no valid", int'(valid_a), 0);
        end
        chk("en low duty holds", int'(duty_a[6:0]), 32);
        en = 1'b1;
        drive(0, PERIOD - 1, 256, 512, 0, 0);
        chk("no early valid after en", int'(valid_a), 0);
        drive(PERIOD - 1, 1, 256, 512, 0, 0);
        chk("first valid 1024 after en", int'(valid_a), 1);
        chk("duty after en", int'(duty_a[6:0]), 32);

        // Comparator edge landing exactly on the window-closing sample.
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int j = 1; j <= 2 * PERIOD; j++) begin
            comp_a[0] = (j >= PERIOD) && (j <= PERIOD + 7);
            comp_a[1] = 1'b0;
            comp_b    = '0;
            @(negedge clk);
            if (j == PERIOD) begin
                chk("sync edge win1 valid", int'(valid_a), 1);
                chk("sync edge win1 duty", int'(duty_a[6:0]), 0);
            end
            if (j == 2 * PERIOD) begin
                chk("sync edge win2 valid", int'(valid_a), 1);
                chk("sync edge win2 duty", int'(duty_a[6:0]), 1);
            end
        end

        repeat (4) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
